sap_prog_loader: RTL and testbench
==================================

Name: sap_prog_loader

Overview:
- Upstream stage of the SAP-1 CPU core. Holds the CPU off while it writes a program into the CPU's 16x8 program/data RAM.
- The program arrives as a byte stream with a valid/ready handshake.
- After the last byte, fills every unwritten RAM location with a fixed word (HLT by default), then releases the CPU.
- Replaces manual switch-loading of RAM; sits between the host/stream source and the SAP RAM write port and run control.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM word width.
- DEPTH, 16, number of RAM words; must equal 2**ADDR_W.
- FILL_WORD, 8'hF0, word written to locations after the last stream byte (SAP HLT).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begins a load; sampled only in IDLE or DONE.
- in_valid  input  1  stream byte valid.
- in_data  input  DATA_W  stream byte.
- in_last  input  1  marks final byte of the program; qualified by in_valid.
- in_ready  output  1  loader accepts a byte this cycle.
- ram_we  output  1  RAM write enable (one word per cycle).
- ram_addr  output  ADDR_W  RAM write address.
- ram_wdata  output  DATA_W  RAM write data.
- cpu_hold  output  1  high = CPU held in reset/stopped.
- done  output  1  a load completed; CPU running.
- err  output  1  sticky; stream exceeded DEPTH bytes without in_last.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, addr counter=0, ram_we=0, ram_addr=0, ram_wdata=0, in_ready=0, cpu_hold=1, done=0, err=0.
- All outputs are registered except in_ready, which equals (state==LOAD).
- States: IDLE, LOAD, FILL, FINISH, DONE.
- IDLE:
  - cpu_hold=1.
  - start=1 -> LOAD, addr=0, err=0, done=0.
  - in_valid is ignored.
- LOAD:
  - A transfer occurs when in_valid && in_ready.
  - On a transfer edge: ram_we<=1, ram_addr<=addr, ram_wdata<=in_data, addr<=addr+1. The write is therefore visible one cycle after acceptance.
  - No transfer: ram_we<=0.
  - Transfer with addr==DEPTH-1: next state FINISH. If in_last=0 on this byte, err<=1 and the remainder of the stream is not accepted (in_ready low from FINISH on).
  - Transfer with in_last=1 and addr<DEPTH-1: next state FILL.
  - Otherwise remain in LOAD. in_valid gaps of any length are allowed.
- FILL:
  - Each cycle: ram_we<=1, ram_addr<=addr, ram_wdata<=FILL_WORD, addr<=addr+1.
  - The edge issuing addr==DEPTH-1 moves to FINISH.
  - Fill writes are back-to-back with no gaps.
- FINISH:
  - Exactly one cycle; the final write (ram_we=1) is visible.
  - Next edge: ram_we<=0, cpu_hold<=0, done<=1, state DONE.
- DONE:
  - cpu_hold=0, done=1, ram_we=0.
  - start=1 -> LOAD: cpu_hold<=1, done<=0, err<=0, addr=0.
- start in LOAD/FILL/FINISH is ignored.
- Address counter is ADDR_W bits. It never wraps within a load, because every path leaves at DEPTH-1.
- Every load writes exactly DEPTH words, each address exactly once, in ascending order.
- cpu_hold is 1 throughout every cycle in which ram_we=1.
- Reset mid-load: immediate return to reset values. The partially written RAM is not cleared. The CPU stays held until a subsequent complete load.

Test Plan:
- Reset release, in_valid=1 with no start -> in_ready=0, ram_we never 1, cpu_hold=1, done=0.
- start, 16 bytes 8'h00..8'h0F back-to-back, in_last on byte 15 -> 16 writes addr 0..15 with data = addr, each one cycle after acceptance; FILL skipped; cpu_hold falls and done rises one cycle after the last write; err=0.
- start, 3 bytes 8'h1E,8'h2F,8'hE0 with in_last on byte 3 and one idle cycle between bytes -> writes addr0=1E, addr1=2F, addr2=E0, then addr3..15=F0 on 13 consecutive cycles, then done=1.
- start, 20 bytes with in_last never set -> 16 writes, err=1, in_ready=0 after the 16th transfer, bytes 17-20 not accepted, done=1.
- Reset pulled low after 5 accepted bytes -> ram_we=0 and cpu_hold=1 with no clock edge; new start then reloads from addr 0.
- Pulse start during FILL, then again in DONE -> first ignored; second re-enters LOAD with cpu_hold=1, done=0, err cleared.

Source files
------------

// File: rtl/sap_prog_loader.sv
// SAP-1 program loader: streams a program into the 16x8 RAM, pads the rest with
// FILL_WORD, and holds the CPU until the whole RAM image has been written.
`timescale 1ns/1ps
module sap_prog_loader #(
  parameter int                 ADDR_W    = 4,
  parameter int                 DATA_W    = 8,
  parameter int                 DEPTH     = 16,
  parameter logic [DATA_W-1:0]  FILL_WORD = 8'hF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte moves when in_valid && in_ready on a rising edge; in_ready
  // depends only on state, so the source may wait on it without a comb loop.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FILL   = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_cpu_hold;
  logic                r_done;
  logic                r_err;

  logic                w_in_load;
  logic                w_xfer;
  logic                w_at_last;

  assign w_in_load = (r_state == S_LOAD);
  assign w_xfer    = in_valid && w_in_load;
  assign w_at_last = (r_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ram_we   <= 1'b0;
          r_cpu_hold <= 1'b1;
          if (start) begin
            r_state <= S_LOAD;
            r_addr  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
          end
        end

        S_LOAD: begin
          if (w_xfer) begin
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_addr;
            r_ram_wdata <= in_data;
            r_addr      <= r_addr + ADDR_W'(1);
            // The RAM is full on the last address whether or not in_last came.
            if (w_at_last) begin
              r_state <= S_FINISH;
              if (!in_last) r_err <= 1'b1;
            end else if (in_last) begin
              r_state <= S_FILL;
            end
          end else begin
            r_ram_we <= 1'b0;
          end
        end

        S_FILL: begin
          r_ram_we    <= 1'b1;
          r_ram_addr  <= r_addr;
          r_ram_wdata <= FILL_WORD;
          r_addr      <= r_addr + ADDR_W'(1);
          if (w_at_last) r_state <= S_FINISH;
        end

        S_FINISH: begin
          r_ram_we   <= 1'b0;
          r_cpu_hold <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= S_DONE;
        end

        S_DONE: begin
          r_ram_we <= 1'b0;
          if (start) begin
            r_state    <= S_LOAD;
            r_addr     <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_load;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sap_prog_loader.sv
// Bench for sap_prog_loader: write scoreboard plus a vector table for the
// short-program / fill case and directed reset and overflow sequences.
`timescale 1ns/1ps
module tb_sap_prog_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready, ram_we, cpu_hold, done, err;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [2:0] dbg_state;

  sap_prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic        sb_en  = 1'b1;
  logic [11:0] exp_q[$];

  typedef struct {
    logic       s, v;
    logic [7:0] d;
    logic       l;
    logic       we;
    logic [3:0] a;
    logic [7:0] wd;
    logic       rdy, hold, dn, er;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic we, input logic rdy,
                           input logic hold, input logic dn, input logic er);
    check({name, "_we"},   32'(ram_we),   32'(we));
    check({name, "_rdy"},  32'(in_ready), 32'(rdy));
    check({name, "_hold"}, 32'(cpu_hold), 32'(hold));
    check({name, "_done"}, 32'(done),     32'(dn));
    check({name, "_err"},  32'(err),      32'(er));
  endtask

  // Drive one cycle of inputs, clock it, then score any RAM write it produced.
  task automatic step(input logic s, input logic v, input logic [7:0] d, input logic l);
    logic [11:0] e;
    start = s; in_valid = v; in_data = d; in_last = l;
    @(posedge clk);
    #1;
    if (sb_en && ram_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr_data", {20'b0, ram_addr, ram_wdata}, {20'b0, e});
      end
      check("hold_during_we", 32'(cpu_hold), 32'd1);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  function automatic void add_vec(input logic s, input logic v, input logic [7:0] d, input logic l,
                                  input logic we, input logic [3:0] a, input logic [7:0] wd,
                                  input logic rdy, input logic hold, input logic dn, input logic er);
    vec_t x;
    x.s = s; x.v = v; x.d = d; x.l = l; x.we = we; x.a = a; x.wd = wd;
    x.rdy = rdy; x.hold = hold; x.dn = dn; x.er = er;
    tbl.push_back(x);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values, asserted between clock edges.
    #2 reset = 1'b0;
    #1;
    check_out("rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // in_valid without start must be ignored.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'hAA, 1'b1);
      check_out($sformatf("nostart%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Full 16-byte program, back to back, in_last on the 16th byte.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("full_start_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'(i)});
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), (i == 15));
      check($sformatf("full_we%0d", i), 32'(ram_we), 32'd1);
      check($sformatf("full_rdy%0d", i), 32'(in_ready), 32'(i < 15));
    end
    check_out("full_finish", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    check_out("full_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_q_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: 20 bytes, never in_last.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check_out("ovf_start", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'(8'hA0 + i)});
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
      if (i < 15)       check_out($sformatf("ovf%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      else if (i == 15) check_out("ovf_last", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      else              check_out($sformatf("ovf_after%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    check("ovf_q_empty", 32'(exp_q.size()), 32'd0);

    // Table: restart from DONE (clears err), 3 bytes with gaps, fill, start ignored in FILL.
    add_vec(1, 0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add_vec(0, 1, 8'h1E, 0, 1, 4'h0, 8'h1E, 1, 1, 0, 0);
    add_vec(0, 0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add_vec(0, 1, 8'h2F, 0, 1, 4'h1, 8'h2F, 1, 1, 0, 0);
    add_vec(0, 0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 0, 0);
    add_vec(0, 1, 8'hE0, 1, 1, 4'h2, 8'hE0, 0, 1, 0, 0);
    for (int k = 3; k < 16; k++)
      add_vec((k == 5), (k == 7), 8'h55, 1'b0, 1'b1, 4'(k), 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(0, 0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 1, 0);
    add_vec(1, 0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 1, 0, 0);

    sb_en = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].l);
      check_out($sformatf("v%0d", i), tbl[i].we, tbl[i].rdy, tbl[i].hold, tbl[i].dn, tbl[i].er);
      if (tbl[i].we) begin
        check($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(tbl[i].a));
        check($sformatf("v%0d_data", i), 32'(ram_wdata), 32'(tbl[i].wd));
      end
    end
    sb_en = 1'b1;

    // Reset after 5 accepted bytes, then a clean reload from address 0.
    for (int i = 0; i < 5; i++) exp_q.push_back({4'(i), 8'(8'h30 + i)});
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    check("mid_we_before_rst", 32'(ram_we), 32'd1);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_out("mid_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("mid_rst_addr", 32'(ram_addr), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle();
    check_out("post_rst_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("reload_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back({4'(i), 8'(8'hC0 + i)});
    for (int i = 4; i < 16; i++) exp_q.push_back({4'(i), 8'hF0});
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), (i == 3));
    for (int c = 0; c < 30 && !done; c++) idle();
    check("reload_done", 32'(done), 32'd1);
    check("reload_hold", 32'(cpu_hold), 32'd0);
    check("reload_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
